gpio16_port: RTL and testbench

- Memory-mapped 16-bit GPIO block implementing an MSP430-style port pair: port x (P1, low byte) and port y (P2, high byte).
- Occupies a 32-byte window starting at START on the CPU memory bus (MAB/MDB).
- Holds IN/OUT/DIR/REN/SEL0/SEL1/SELC/IES/IE/IFG registers plus P1IV/P2IV interrupt vector registers.
- Drives pin-control outputs and one interrupt request per port.

---
 rtl/gpio16_port.sv | 213 +++++++++++++++++++++
 tb/tb_gpio16_port.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio16_port.sv
// MSP430-style 16-bit GPIO port pair (P1 = low byte lane, P2 = high byte lane)
// behind a 32-byte memory-mapped register window.

module gpio16_lane #(
  parameter int VEC_W = 8,
  parameter int IVW   = $clog2(2*VEC_W+1)
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic [VEC_W-1:0] pinIn,
  input  logic [VEC_W-1:0] wrData,
  input  logic             wrOut,
  input  logic             wrDir,
  input  logic             wrRen,
  input  logic             wrSel0,
  input  logic             wrSel1,
  input  logic             wrSelc,
  input  logic             wrIes,
  input  logic             wrIe,
  input  logic             wrIfg,
  input  logic             wrIv,
  input  logic             rdIv,
  output logic [VEC_W-1:0] inReg,
  output logic [VEC_W-1:0] outReg,
  output logic [VEC_W-1:0] dirReg,
  output logic [VEC_W-1:0] renReg,
  output logic [VEC_W-1:0] sel0Reg,
  output logic [VEC_W-1:0] sel1Reg,
  output logic [VEC_W-1:0] iesReg,
  output logic [VEC_W-1:0] ieReg,
  output logic [VEC_W-1:0] ifgReg,
  output logic [IVW-1:0]   iv
);

  logic [VEC_W-1:0] pend, lowBit, edgeHit, ifgNext;

  always_comb begin
    pend    = ifgReg & ieReg;
    lowBit  = pend & (~pend + VEC_W'(1));
    iv      = '0;
    // Scan downwards so the lowest pending pin wins priority.
    for (int n = VEC_W-1; n >= 0; n--)
      if (pend[n]) iv = IVW'(2*(n+1));
    edgeHit = (iesReg & inReg & ~pinIn) | (~iesReg & ~inReg & pinIn);
    ifgNext = ifgReg;
    if (wrIv)  ifgNext = '0;
    if (rdIv)  ifgNext = ifgNext & ~lowBit;
    if (wrIfg) ifgNext = wrData;
    // Hardware edge set is applied last so it beats any software clear.
    ifgNext = ifgNext | edgeHit;
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      inReg   <= '0;
      outReg  <= '0;
      dirReg  <= '0;
      renReg  <= '0;
      sel0Reg <= '0;
      sel1Reg <= '0;
      iesReg  <= '0;
      ieReg   <= '0;
      ifgReg  <= '0;
    end else begin
      inReg  <= pinIn;
      ifgReg <= ifgNext;
      if (wrOut) outReg <= wrData;
      if (wrDir) dirReg <= wrData;
      if (wrRen) renReg <= wrData;
      if (wrIes) iesReg <= wrData;
      if (wrIe)  ieReg  <= wrData;
      if (wrSel0)      sel0Reg <= wrData;
      else if (wrSelc) sel0Reg <= sel0Reg ^ wrData;
      if (wrSel1)      sel1Reg <= wrData;
      else if (wrSelc) sel1Reg <= sel1Reg ^ wrData;
    end
  end

endmodule

module gpio16_port #(
  parameter logic [15:0] START = 16'h0200
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic [15:0] MAB,
  input  logic [15:0] MDBwrite,
  input  logic        MW,
  input  logic        BW,
  input  logic [7:0]  PxIN,
  input  logic [7:0]  PyIN,
  output logic [15:0] MDBread,
  output logic        PxINT,
  output logic        PyINT,
  output logic [7:0]  PxOUT,
  output logic [7:0]  PxDIR,
  output logic [7:0]  PxREN,
  output logic [7:0]  PxSEL0,
  output logic [7:0]  PxSEL1,
  output logic [7:0]  PyOUT,
  output logic [7:0]  PyDIR,
  output logic [7:0]  PyREN,
  output logic [7:0]  PySEL0,
  output logic [7:0]  PySEL1
);

  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 8;
  localparam int IVW       = $clog2(2*VEC_W+1);

  // Word index (byte offset / 2) of each register.
  localparam logic [3:0] IDX_IN   = 4'h0;
  localparam logic [3:0] IDX_OUT  = 4'h1;
  localparam logic [3:0] IDX_DIR  = 4'h2;
  localparam logic [3:0] IDX_REN  = 4'h3;
  localparam logic [3:0] IDX_SEL0 = 4'h5;
  localparam logic [3:0] IDX_SEL1 = 4'h6;
  localparam logic [3:0] IDX_P1IV = 4'h7;
  localparam logic [3:0] IDX_SELC = 4'hB;
  localparam logic [3:0] IDX_IES  = 4'hC;
  localparam logic [3:0] IDX_IE   = 4'hD;
  localparam logic [3:0] IDX_IFG  = 4'hE;
  localparam logic [3:0] IDX_P2IV = 4'hF;

  logic [15:0] offs;
  logic        sel, rdAcc, wrAcc;
  logic [3:0]  idx;
  logic [15:0] rdWord;

  logic [NUM_LANES-1:0][VEC_W-1:0] pinIn, wrData;
  logic [NUM_LANES-1:0][VEC_W-1:0] inR, outR, dirR, renR, sel0R, sel1R, iesR, ieR, ifgR;
  logic [NUM_LANES-1:0][IVW-1:0]   iv;

  // The high-bits test plus the lower bound also rejects wrap past 16'hFFFF.
  assign offs  = MAB - START;
  assign sel   = (MAB >= START) && (offs[15:5] == '0);
  assign idx   = offs[4:1];
  assign rdAcc = sel & ~MW;
  assign wrAcc = sel & MW;

  assign pinIn     = {PyIN, PxIN};
  assign wrData[0] = MDBwrite[7:0];
  assign wrData[1] = BW ? MDBwrite[7:0] : MDBwrite[15:8];

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    localparam logic [3:0] IV_IDX = (l == 0) ? IDX_P1IV : IDX_P2IV;
    logic laneWr;
    assign laneWr = wrAcc & (~BW | (offs[0] == 1'(l)));

    gpio16_lane #(.VEC_W(VEC_W), .IVW(IVW)) uLane (
      .MCLK   (MCLK),
      .reset  (reset),
      .pinIn  (pinIn[l]),
      .wrData (wrData[l]),
      .wrOut  (laneWr && idx == IDX_OUT),
      .wrDir  (laneWr && idx == IDX_DIR),
      .wrRen  (laneWr && idx == IDX_REN),
      .wrSel0 (laneWr && idx == IDX_SEL0),
      .wrSel1 (laneWr && idx == IDX_SEL1),
      .wrSelc (laneWr && idx == IDX_SELC),
      .wrIes  (laneWr && idx == IDX_IES),
      .wrIe   (laneWr && idx == IDX_IE),
      .wrIfg  (laneWr && idx == IDX_IFG),
      .wrIv   (wrAcc && idx == IV_IDX),
      .rdIv   (rdAcc && idx == IV_IDX),
      .inReg  (inR[l]),
      .outReg (outR[l]),
      .dirReg (dirR[l]),
      .renReg (renR[l]),
      .sel0Reg(sel0R[l]),
      .sel1Reg(sel1R[l]),
      .iesReg (iesR[l]),
      .ieReg  (ieR[l]),
      .ifgReg (ifgR[l]),
      .iv     (iv[l])
    );
  end

  always_comb begin
    rdWord = '0;
    case (idx)
      IDX_IN:   rdWord = inR;
      IDX_OUT:  rdWord = outR;
      IDX_DIR:  rdWord = dirR;
      IDX_REN:  rdWord = renR;
      IDX_SEL0: rdWord = sel0R;
      IDX_SEL1: rdWord = sel1R;
      IDX_P1IV: rdWord = 16'(iv[0]);
      IDX_IES:  rdWord = iesR;
      IDX_IE:   rdWord = ieR;
      IDX_IFG:  rdWord = ifgR;
      IDX_P2IV: rdWord = 16'(iv[1]);
      default:  rdWord = '0;
    endcase
    MDBread = '0;
    if (rdAcc)
      MDBread = BW ? {8'h00, (offs[0] ? rdWord[15:8] : rdWord[7:0])} : rdWord;
  end

  assign PxINT  = |(ifgR[0] & ieR[0]);
  assign PyINT  = |(ifgR[1] & ieR[1]);
  assign PxOUT  = outR[0];
  assign PxDIR  = dirR[0];
  assign PxREN  = renR[0];
  assign PxSEL0 = sel0R[0];
  assign PxSEL1 = sel1R[0];
  assign PyOUT  = outR[1];
  assign PyDIR  = dirR[1];
  assign PyREN  = renR[1];
  assign PySEL0 = sel0R[1];
  assign PySEL1 = sel1R[1];

endmodule

// File: tb/tb_gpio16_port.sv
// Bench for gpio16_port: directed scenarios with constant expectations, then
// random bus/pin traffic against a register-map reference model.

module tb_gpio16_port;

  localparam logic [15:0] START = 16'h0200;

  logic        MCLK = 1'b0;
  logic        reset;
  logic [15:0] MAB, MDBwrite, MDBread;
  logic        MW, BW, PxINT, PyINT;
  logic [7:0]  PxIN, PyIN;
  logic [7:0]  PxOUT, PxDIR, PxREN, PxSEL0, PxSEL1;
  logic [7:0]  PyOUT, PyDIR, PyREN, PySEL0, PySEL1;

  int total = 0;
  int bad   = 0;

  // Reference model state, indexed by port (0 = P1, 1 = P2).
  logic [1:0][7:0] mIn, mOut, mDir, mRen, mSel0, mSel1, mIes, mIe, mIfg;

  gpio16_port #(.START(START)) dut (
    .MCLK(MCLK), .reset(reset), .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW),
    .PxIN(PxIN), .PyIN(PyIN), .MDBread(MDBread), .PxINT(PxINT), .PyINT(PyINT),
    .PxOUT(PxOUT), .PxDIR(PxDIR), .PxREN(PxREN), .PxSEL0(PxSEL0), .PxSEL1(PxSEL1),
    .PyOUT(PyOUT), .PyDIR(PyDIR), .PyREN(PyREN), .PySEL0(PySEL0), .PySEL1(PySEL1)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick;
    @(posedge MCLK);
    #1;
  endtask

  task automatic idle;
    MW = 1'b0; BW = 1'b0; MAB = 16'h0000; MDBwrite = 16'h0000;
  endtask

  task automatic wrB(input logic [15:0] a, input logic [7:0] d);
    MAB = a; MDBwrite = {8'hC3, d}; MW = 1'b1; BW = 1'b1;
    tick; idle;
  endtask

  task automatic wrW(input logic [15:0] a, input logic [15:0] d);
    MAB = a; MDBwrite = d; MW = 1'b1; BW = 1'b0;
    tick; idle;
  endtask

  // Combinational read with no clock edge, so no IV side effect.
  task automatic rd(input logic [15:0] a, input logic bw, output logic [15:0] d);
    MAB = a; MW = 1'b0; BW = bw;
    #1 d = MDBread;
    idle;
  endtask

  task automatic pulseReset;
    idle;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  function automatic logic [15:0] mIv(input int p);
    for (int n = 0; n < 8; n++)
      if (mIfg[p][n] && mIe[p][n]) return 16'(2*(n+1));
    return 16'h0000;
  endfunction

  function automatic logic [15:0] mRead(input logic [15:0] a, input logic mw, input logic bw);
    logic [15:0] w;
    int off;
    if (mw || a < START || a >= START + 32) return 16'h0000;
    off = int'(a - START);
    case (off & 'h1E)
      'h00: w = mIn;
      'h02: w = mOut;
      'h04: w = mDir;
      'h06: w = mRen;
      'h0A: w = mSel0;
      'h0C: w = mSel1;
      'h0E: w = mIv(0);
      'h18: w = mIes;
      'h1A: w = mIe;
      'h1C: w = mIfg;
      'h1E: w = mIv(1);
      default: w = 16'h0000;
    endcase
    if (bw) return off[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    return w;
  endfunction

  // One clock edge of the register map as described behaviourally.
  task automatic mStep(input logic [15:0] a, input logic [15:0] wd, input logic mw,
                       input logic bw, input logic [7:0] px, input logic [7:0] py);
    logic [1:0][7:0] pins, setMask;
    logic [7:0] b;
    logic inWin;
    int off, base;
    pins  = {py, px};
    inWin = (a >= START) && (a < START + 32);
    off   = int'(a - START);
    base  = off & 'h1E;
    for (int p = 0; p < 2; p++)
      for (int n = 0; n < 8; n++)
        setMask[p][n] = mIes[p][n] ? (mIn[p][n] && !pins[p][n]) : (!mIn[p][n] && pins[p][n]);
    if (inWin && !mw) begin
      for (int p = 0; p < 2; p++)
        if (base == (p == 0 ? 'h0E : 'h1E)) begin
          for (int n = 0; n < 8; n++)
            if (mIfg[p][n] && mIe[p][n]) begin mIfg[p][n] = 1'b0; break; end
        end
    end
    if (inWin && mw) begin
      if (base == 'h0E) mIfg[0] = 8'h00;
      if (base == 'h1E) mIfg[1] = 8'h00;
      for (int p = 0; p < 2; p++)
        if (!bw || off[0] == p[0]) begin
          b = bw ? wd[7:0] : (p == 1 ? wd[15:8] : wd[7:0]);
          case (base)
            'h02: mOut[p] = b;
            'h04: mDir[p] = b;
            'h06: mRen[p] = b;
            'h0A: mSel0[p] = b;
            'h0C: mSel1[p] = b;
            'h16: begin mSel0[p] = mSel0[p] ^ b; mSel1[p] = mSel1[p] ^ b; end
            'h18: mIes[p] = b;
            'h1A: mIe[p] = b;
            'h1C: mIfg[p] = b;
            default: ;
          endcase
        end
    end
    mIfg = mIfg | setMask;
    mIn  = pins;
  endtask

  task automatic test_reset;
    PxIN = 8'h00; PyIN = 8'h00;
    pulseReset;
    total++;
    if ({PxOUT, PxDIR, PxREN, PxSEL0, PxSEL1, PyOUT, PyDIR, PyREN, PySEL0, PySEL1, PxINT, PyINT} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h/%h/%h/%h/%h %h/%h/%h/%h/%h int=%b%b want all 0",
        PxOUT, PxDIR, PxREN, PxSEL0, PxSEL1, PyOUT, PyDIR, PyREN, PySEL0, PySEL1, PxINT, PyINT);
    end
    total++;
    if (MDBread !== 16'h0000) begin bad++; $display("FAIL reset_mdb_idle: got %h want 0000", MDBread); end
  endtask

  task automatic test_bus_read;
    logic [15:0] d;
    PxIN = 8'h5A; PyIN = 8'hA5;
    tick;
    rd(START, 1'b1, d);
    total++; if (d !== 16'h005A) begin bad++; $display("FAIL byte_read_pain_lo: got %h want 005A", d); end
    rd(START + 1, 1'b1, d);
    total++; if (d !== 16'h00A5) begin bad++; $display("FAIL byte_read_pain_hi: got %h want 00A5", d); end
    rd(START, 1'b0, d);
    total++; if (d !== 16'hA55A) begin bad++; $display("FAIL word_read_pain: got %h want A55A", d); end
    wrW(START, 16'hFFFF);
    wrW(START + 16'h0E, 16'hFFFF);
    total++;
    if ({PxOUT, PxDIR, PxREN, PxSEL0, PxSEL1, PyOUT, PyDIR, PyREN, PySEL0, PySEL1} !== '0) begin
      bad++; $display("FAIL ro_write_ignored: got regs changed want all 0");
    end
    rd(START, 1'b0, d);
    total++; if (d !== 16'hA55A) begin bad++; $display("FAIL pain_after_write: got %h want A55A", d); end
    rd(START + 16'h0020, 1'b0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL read_above_window: got %h want 0000", d); end
    rd(START - 16'h0002, 1'b0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL read_below_window: got %h want 0000", d); end
    rd(START + 16'h0008, 1'b0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL read_reserved: got %h want 0000", d); end
  endtask

  task automatic test_dir;
    logic [15:0] d;
    wrW(START + 16'h04, 16'hFFF9);
    total++;
    if ({PxDIR, PyDIR} !== 16'hF9FF) begin bad++; $display("FAIL word_write_dir: got %h/%h want F9/FF", PxDIR, PyDIR); end
    wrB(START + 16'h05, 8'h00);
    total++;
    if ({PxDIR, PyDIR} !== 16'hF900) begin bad++; $display("FAIL byte_write_dir_hi0: got %h/%h want F9/00", PxDIR, PyDIR); end
    wrB(START + 16'h05, 8'hFF);
    total++;
    if (PyDIR !== 8'hFF) begin bad++; $display("FAIL byte_write_dir_hiFF: got %h want FF", PyDIR); end
    rd(START + 16'h04, 1'b0, d);
    total++; if (d !== 16'hFFF9) begin bad++; $display("FAIL read_dir: got %h want FFF9", d); end
  endtask

  task automatic test_p1_irq;
    logic [15:0] d;
    wrB(START + 16'h06, 8'h06);
    wrB(START + 16'h02, 8'h06);
    wrB(START + 16'h18, 8'h06);
    wrB(START + 16'h1A, 8'h06);
    wrW(START + 16'h1C, 16'h0000);
    total++;
    if ({PxREN, PxOUT} !== 16'h0606) begin bad++; $display("FAIL p1_setup: got ren=%h out=%h want 06/06", PxREN, PxOUT); end
    total++; if (PxINT !== 1'b0) begin bad++; $display("FAIL p1_int_idle: got %b want 0", PxINT); end
    PxIN = 8'h58;
    tick;
    total++; if (PxINT !== 1'b1) begin bad++; $display("FAIL p1_int_set: got %b want 1", PxINT); end
    rd(START + 16'h1C, 1'b1, d);
    total++; if (d !== 16'h0002) begin bad++; $display("FAIL p1_ifg_fall: got %h want 0002", d); end
    MAB = START + 16'h0E; MW = 1'b0; BW = 1'b0;
    #1;
    total++; if (MDBread !== 16'h0004) begin bad++; $display("FAIL p1_iv: got %h want 0004", MDBread); end
    tick; idle; #1;
    total++; if (PxINT !== 1'b0) begin bad++; $display("FAIL p1_int_after_iv: got %b want 0", PxINT); end
    rd(START + 16'h1C, 1'b1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL p1_ifg_after_iv: got %h want 0000", d); end
  endtask

  task automatic test_priority;
    logic [15:0] d;
    PxIN = 8'h5F; tick;
    PxIN = 8'h5B; tick;
    PxIN = 8'h59; tick;
    rd(START + 16'h1C, 1'b1, d);
    total++; if (d !== 16'h0007) begin bad++; $display("FAIL prio_ifg: got %h want 0007", d); end
    MAB = START + 16'h0E; MW = 1'b0; BW = 1'b0;
    #1;
    total++; if (MDBread !== 16'h0004) begin bad++; $display("FAIL prio_iv1: got %h want 0004", MDBread); end
    tick;
    total++; if (MDBread !== 16'h0006) begin bad++; $display("FAIL prio_iv2: got %h want 0006", MDBread); end
    tick; idle; #1;
    total++; if (PxINT !== 1'b0) begin bad++; $display("FAIL prio_int_drop: got %b want 0", PxINT); end
    rd(START + 16'h1C, 1'b1, d);
    total++; if (d !== 16'h0001) begin bad++; $display("FAIL prio_ifg_left: got %h want 0001", d); end
    rd(START + 16'h0E, 1'b1, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL prio_iv_empty: got %h want 0000", d); end
  endtask

  task automatic test_selc;
    logic [15:0] d;
    pulseReset;
    total++;
    if ({PxOUT, PxDIR, PxREN, PxSEL0, PxSEL1, PyOUT, PyDIR, PyREN, PySEL0, PySEL1, PxINT, PyINT} !== '0) begin
      bad++; $display("FAIL midrun_reset: got nonzero outputs want all 0");
    end
    wrW(START + 16'h16, 16'hA55A);
    total++;
    if ({PxSEL0, PxSEL1, PySEL0, PySEL1} !== 32'h5A5AA5A5) begin
      bad++; $display("FAIL selc_toggle: got %h %h %h %h want 5A 5A A5 A5", PxSEL0, PxSEL1, PySEL0, PySEL1);
    end
    rd(START + 16'h16, 1'b0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL selc_reads0: got %h want 0000", d); end
    wrB(START + 16'h17, 8'h0F);
    total++;
    if ({PxSEL0, PxSEL1, PySEL0, PySEL1} !== 32'h5A5AAAAA) begin
      bad++; $display("FAIL selc_byte: got %h %h %h %h want 5A 5A AA AA", PxSEL0, PxSEL1, PySEL0, PySEL1);
    end
  endtask

  task automatic test_simultaneous;
    logic [15:0] d;
    PxIN = 8'h00; PyIN = 8'h00;
    tick;
    wrW(START + 16'h18, 16'h0202);
    wrW(START + 16'h1C, 16'h0000);
    PxIN = 8'h02;
    tick;
    rd(START + 16'h1C, 1'b0, d);
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL ies_no_rise: got %h want 0000", d); end
    PxIN = 8'h00;
    MAB = START + 16'h1C; MDBwrite = 16'h0000; MW = 1'b1; BW = 1'b1;
    tick; idle;
    rd(START + 16'h1C, 1'b0, d);
    total++; if (d !== 16'h0002) begin bad++; $display("FAIL set_beats_swclear: got %h want 0002", d); end
    wrW(START + 16'h1A, 16'h0202);
    PyIN = 8'h02;
    tick;
    PyIN = 8'h00;
    MAB = START + 16'h1E; MDBwrite = 16'h0000; MW = 1'b1; BW = 1'b0;
    tick; idle; #1;
    total++; if (PyINT !== 1'b1) begin bad++; $display("FAIL set_beats_ivwrite: got %b want 1", PyINT); end
    rd(START + 16'h1E, 1'b0, d);
    total++; if (d !== 16'h0004) begin bad++; $display("FAIL p2_iv: got %h want 0004", d); end
    rd(START + 16'h1C, 1'b0, d);
    total++; if (d !== 16'h0202) begin bad++; $display("FAIL both_ifg: got %h want 0202", d); end
    wrW(START + 16'h0E, 16'h1234);
    rd(START + 16'h1C, 1'b0, d);
    total++; if (d !== 16'h0200) begin bad++; $display("FAIL p1iv_write_clear: got %h want 0200", d); end
  endtask

  task automatic test_random;
    logic [15:0] a, wd, expRd;
    logic mw, bw;
    logic [7:0] px, py;
    logic [81:0] expOut, gotOut;
    pulseReset;
    mIn = '0; mOut = '0; mDir = '0; mRen = '0; mSel0 = '0; mSel1 = '0;
    mIes = '0; mIe = '0; mIfg = '0;
    for (int it = 0; it < 600; it++) begin
      case ($urandom_range(0, 9))
        0:       a = START + 16'($urandom_range(32, 40));
        1:       a = START - 16'($urandom_range(1, 4));
        default: a = START + 16'($urandom_range(0, 31));
      endcase
      wd = 16'($urandom);
      mw = ($urandom_range(0, 2) == 0);
      bw = 1'($urandom);
      px = ($urandom_range(0, 1) == 0) ? mIn[0] : 8'($urandom);
      py = ($urandom_range(0, 1) == 0) ? mIn[1] : 8'($urandom);
      MAB = a; MDBwrite = wd; MW = mw; BW = bw; PxIN = px; PyIN = py;
      #1;
      expRd = mRead(a, mw, bw);
      total++;
      if (MDBread !== expRd) begin
        bad++; $display("FAIL rand_read it=%0d addr=%h mw=%b bw=%b: got %h want %h", it, a, mw, bw, MDBread, expRd);
      end
      mStep(a, wd, mw, bw, px, py);
      tick;
      expOut = {mOut[0], mDir[0], mRen[0], mSel0[0], mSel1[0],
                mOut[1], mDir[1], mRen[1], mSel0[1], mSel1[1],
                |(mIfg[0] & mIe[0]), |(mIfg[1] & mIe[1])};
      gotOut = {PxOUT, PxDIR, PxREN, PxSEL0, PxSEL1, PyOUT, PyDIR, PyREN, PySEL0, PySEL1, PxINT, PyINT};
      total++;
      if (gotOut !== expOut) begin
        bad++; $display("FAIL rand_outputs it=%0d: got %h want %h", it, gotOut, expOut);
      end
    end
    idle;
  endtask

  initial begin
    reset = 1'b0;
    idle;
    PxIN = 8'h00; PyIN = 8'h00;
    test_reset;
    test_bus_read;
    test_dir;
    test_p1_irq;
    test_priority;
    test_selc;
    test_simultaneous;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
